prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Program-level controller that sits directly upstream of the instruction-fetch stage. It sequences the 2-3 benchmark programs in order: it holds the PC while idle, and injects a one-cycle absolute jump to the selected program's base address when the bench requests a run. It then watches for the decoder's halt indication and returns a level Ack to the bench. Its Start/SeqJump/SeqTarget outputs drive the fetch stage's Start input and feed the fetch stage's Jump/Target muxes alongside the decoder's branch signals.

## Interface
- NUM_PROGS, 3: number of programs sequenced; legal range 1..4.
- PROG_BASE0, 10'd0: PC of program 0's first instruction.
- PROG_BASE1, 10'd256: PC of program 1's first instruction.
- PROG_BASE2, 10'd512: PC of program 2's first instruction.
- PROG_BASE3, 10'd768: PC of program 3's first instruction.
- CYC_W, 16: width of the cycle counter.

- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high; forces IDLE.
- Req  in  1  bench request; level, held high until Ack is seen.
- Halt  in  1  decoder saw the halt instruction in the current cycle.
- Start  out  1  hold-PC to the fetch stage.
- SeqJump  out  1  one-cycle absolute jump request to the fetch stage.
- SeqTarget  out  10  jump target, equal to PROG_BASE[ProgIdx].
- SeqAbsOrRel  out  1  constant 0 (absolute).
- ProgIdx  out  2  index of the current/next program.
- Busy  out  1  high in LOAD and RUN.
- Ack  out  1  program finished; high in DONE.
- CycleCount  out  CYC_W  cycles spent in RUN for the last/current program.

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are decoded from the registered state; there is no combinational Req/Halt-to-output path.
- IDLE:
  - Outputs: Start=1, SeqJump=0, Busy=0, Ack=0.
  - Req=1 sampled → LOAD.
- LOAD (exactly one cycle):
  - Outputs: Start=0, SeqJump=1, SeqTarget=PROG_BASE[ProgIdx], Busy=1.
  - CycleCount clears to 0.
  - Always → RUN. Halt is ignored.
- RUN:
  - Outputs: Start=0, SeqJump=0, Busy=1.
  - CycleCount increments each cycle, including the cycle Halt is sampled.
  - Halt=1 → DONE. Req is ignored.
- DONE:
  - Outputs: Start=1, Ack=1, Busy=0. CycleCount holds.
  - Req=0 sampled → IDLE.
  - On that same edge ProgIdx advances: ProgIdx+1, or 0 if ProgIdx==NUM_PROGS-1.
- Halt outside RUN has no effect. Req high outside IDLE/DONE has no effect.
- SeqTarget is driven with PROG_BASE[ProgIdx] in every state. SeqJump alone qualifies it.
- Reset (any state, including mid-RUN):
  - Next state IDLE; ProgIdx=0; CycleCount=0.
  - Outputs after reset: Start=1, SeqJump=0, SeqAbsOrRel=0, Busy=0, Ack=0, SeqTarget=PROG_BASE0.
- CycleCount saturates at all-ones and does not wrap.
- NUM_PROGS=1: ProgIdx stays 0.

## Timing
- Req→jump latency: Req high at edge N moves to LOAD after N. The fetch stage loads PROG_BASE at edge N+1, so the first instruction executes in cycle N+1..N+2.
- Halt→Ack latency: Halt sampled at edge M gives Ack=1 after M, with Start=1 in the same cycle. The fetch stage's PC freezes from edge M+1 onward.
- Ack stays high until Req=0 is sampled. Ack drops in the cycle after that edge.
- Minimum request-to-request spacing is 1 IDLE cycle. Req may rise in the first IDLE cycle.
- CycleCount equals the number of RUN cycles, counting the Halt cycle. Example: Halt on the 5th RUN cycle gives 5.

## Configuration
- Macro SEQ_CYCLE_COUNT_EN.
- Defined: CycleCount register and increment/saturate logic are present as described above.
- Undefined: no counter flops; CycleCount is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset then idle: after Reset, hold Req=0 for 10 cycles → Start=1, SeqJump=0, Ack=0, ProgIdx=0, SeqTarget=0 throughout.
- Single run: Req=1, Halt pulsed on the 7th RUN cycle → SeqJump=1 for exactly one cycle with SeqTarget=0, then Ack=1, and CycleCount=7 when the counter is enabled.
- Three-program sequence: three Req/Ack handshakes → SeqTarget=0, 256, 512 in successive LOAD cycles. A fourth run wraps to ProgIdx=0 and target 0.
- Spurious Halt: Halt=1 in IDLE, LOAD and DONE → no state change. Halt in LOAD does not reach DONE; the FSM stays in RUN until a later Halt.
- Reset mid-RUN: assert Reset on the 3rd RUN cycle of program 1 → next cycle in IDLE, ProgIdx=0, CycleCount=0, Ack=0.
- Saturation: with CYC_W=4, 20 RUN cycles → CycleCount=15 and holds. With SEQ_CYCLE_COUNT_EN undefined → CycleCount=0 always.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program-level sequencer ahead of instruction fetch: holds the PC while idle, injects
// a one-cycle jump to each program's base, and acks on halt. Macro SEQ_CYCLE_COUNT_EN adds the RUN cycle counter.
module prog_sequencer #(
  parameter int         NUM_PROGS  = 3,
  parameter logic [9:0] PROG_BASE0 = 10'd0,
  parameter logic [9:0] PROG_BASE1 = 10'd256,
  parameter logic [9:0] PROG_BASE2 = 10'd512,
  parameter logic [9:0] PROG_BASE3 = 10'd768,
  parameter int         CYC_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  input  logic             Halt,
  output logic             Start,
  output logic             SeqJump,
  output logic [9:0]       SeqTarget,
  output logic             SeqAbsOrRel,
  output logic [1:0]       ProgIdx,
  output logic             Busy,
  output logic             Ack,
  output logic [CYC_W-1:0] CycleCount
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      // program index advances as the bench releases Req after Ack
      if (state_q == DONE && !Req)
        idx_q <= (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    Start   = 1'b0;
    SeqJump = 1'b0;
    Busy    = 1'b0;
    Ack     = 1'b0;
    case (state_q)
      IDLE: begin
        Start = 1'b1;
        if (Req) state_d = LOAD;
      end
      LOAD: begin
        SeqJump = 1'b1;
        Busy    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (Halt) state_d = DONE;
      end
      DONE: begin
        Start = 1'b1;
        Ack   = 1'b1;
        if (!Req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    SeqTarget = PROG_BASE0;
      2'd1:    SeqTarget = PROG_BASE1;
      2'd2:    SeqTarget = PROG_BASE2;
      default: SeqTarget = PROG_BASE3;
    endcase
  end

  assign SeqAbsOrRel = 1'b0;
  assign ProgIdx     = idx_q;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [CYC_W-1:0] cnt_q;

  // counts every RUN cycle including the halt cycle; sticks at all-ones
  always_ff @(posedge Clk) begin
    if (Reset)
      cnt_q <= '0;
    else if (state_q == LOAD)
      cnt_q <= '0;
    else if (state_q == RUN && cnt_q != '1)
      cnt_q <= cnt_q + CYC_W'(1);
  end

  assign CycleCount = cnt_q;
`else
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized handshake bench for prog_sequencer; expectations come from run counts and run lengths.
module tb_prog_sequencer;

  localparam int NP = 3;

  logic        Clk = 1'b0;
  logic        Reset, Req, Halt;
  logic        Start, SeqJump, SeqAbsOrRel, Busy, Ack;
  logic [9:0]  SeqTarget;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;
  logic        s_Start, s_SeqJump, s_SeqAbsOrRel, s_Busy, s_Ack;
  logic [9:0]  s_SeqTarget;
  logic [1:0]  s_ProgIdx;
  logic [3:0]  s_CycleCount;

  int n_chk = 0, n_fail = 0;
  int idx_model = 0;
  int last_len = 0;
  logic [9:0] base [4];

  always #5 Clk = ~Clk;

  prog_sequencer #(.NUM_PROGS(NP)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Halt(Halt),
    .Start(Start), .SeqJump(SeqJump), .SeqTarget(SeqTarget), .SeqAbsOrRel(SeqAbsOrRel),
    .ProgIdx(ProgIdx), .Busy(Busy), .Ack(Ack), .CycleCount(CycleCount));

  // single-program, narrow-counter instance sees the same stimulus
  prog_sequencer #(.NUM_PROGS(1), .CYC_W(4)) dut_s (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Halt(Halt),
    .Start(s_Start), .SeqJump(s_SeqJump), .SeqTarget(s_SeqTarget), .SeqAbsOrRel(s_SeqAbsOrRel),
    .ProgIdx(s_ProgIdx), .Busy(s_Busy), .Ack(s_Ack), .CycleCount(s_CycleCount));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int n, input int w);
`ifdef SEQ_CYCLE_COUNT_EN
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".start"}, Start, 1);
    chk({tag, ".jump"}, SeqJump, 0);
    chk({tag, ".busy"}, Busy, 0);
    chk({tag, ".ack"}, Ack, 0);
    chk({tag, ".abs"}, SeqAbsOrRel, 0);
    chk({tag, ".idx"}, ProgIdx, idx_model);
    chk({tag, ".tgt"}, SeqTarget, base[idx_model]);
    chk({tag, ".cnt"}, CycleCount, exp_cnt(last_len, 16));
    chk({tag, ".s_cnt"}, s_CycleCount, exp_cnt(last_len, 4));
    chk({tag, ".s_ack"}, s_Ack, 0);
  endtask

  // one full handshake; reset_at>0 asserts Reset on that RUN cycle instead of halting
  task automatic run_prog(input int len, input int reset_at);
    chk_idle("pre");
    Req  = 1'b1;
    Halt = 1'($urandom);
    step();
    chk("load.jump", SeqJump, 1);
    chk("load.tgt", SeqTarget, base[idx_model]);
    chk("load.idx", ProgIdx, idx_model);
    chk("load.busy", Busy, 1);
    chk("load.start", Start, 0);
    chk("load.s_tgt", s_SeqTarget, 0);
    chk("load.s_jump", s_SeqJump, 1);
    Halt = 1'($urandom);
    step();
    for (int i = 1; i <= len; i++) begin
      chk("run.jump", SeqJump, 0);
      chk("run.busy", Busy, 1);
      chk("run.ack", Ack, 0);
      chk("run.start", Start, 0);
      chk("run.cnt", CycleCount, exp_cnt(i - 1, 16));
      chk("run.s_cnt", s_CycleCount, exp_cnt(i - 1, 4));
      Req = 1'($urandom);
      if (i == reset_at) begin
        Reset = 1'b1;
        Halt  = 1'b0;
        step();
        Reset = 1'b0;
        Req   = 1'b0;
        idx_model = 0;
        last_len  = 0;
        chk_idle("rst");
        return;
      end
      Halt = (i == len);
      step();
    end
    Halt = 1'b0;
    Req  = 1'b1;
    for (int h = 0; h < 1 + int'($urandom_range(0, 3)); h++) begin
      chk("done.ack", Ack, 1);
      chk("done.start", Start, 1);
      chk("done.busy", Busy, 0);
      chk("done.cnt", CycleCount, exp_cnt(len, 16));
      chk("done.s_cnt", s_CycleCount, exp_cnt(len, 4));
      chk("done.s_ack", s_Ack, 1);
      Halt = 1'($urandom);
      step();
    end
    Req  = 1'b0;
    Halt = 1'($urandom);
    step();
    Halt = 1'b0;
    idx_model = (idx_model + 1) % NP;
    last_len  = len;
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
      chk_idle("gap");
      Halt = 1'($urandom);
      step();
      Halt = 1'b0;
    end
  endtask

  initial begin
    base[0] = 10'd0; base[1] = 10'd256; base[2] = 10'd512; base[3] = 10'd768;
    Reset = 1'b1; Req = 1'b0; Halt = 1'b0;
    step();
    step();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_idle("reset_idle");
      step();
    end
    run_prog(7, 0);                      // program 0
    run_prog(6, 3);                      // reset on 3rd RUN cycle of program 1
    for (int r = 0; r < 4; r++)          // 0,1,2 then wrap to 0
      run_prog(int'($urandom_range(1, 10)), 0);
    run_prog(20, 0);                     // saturates the 4-bit counter
    for (int r = 0; r < 10; r++)
      run_prog(int'($urandom_range(1, 24)), 0);
    chk_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
